cv32e40p_wfi_sleep_sequencer: RTL
=================================

Name: cv32e40p_wfi_sleep_sequencer

Overview:
- Sequences WFI sleep entry and exit for the core clock gate.
- Runs on the free-running clock so it keeps operating while the core clock is gated.
- Accepts a WFI request from the controller, waits for IF/LSU/APU to drain, then gates the clock. On a wake event it ungates the clock, allows a fixed settle delay, and returns completion to the controller.
- Produces clock_en_o for the core clock gate and core_sleep_o for the SoC.

Parameters:
WAKE_DELAY, 2, cycles clock_en_o is held high in WAKE before wfi_done_o; 0 means return directly from SLEEP to RUN
DRAIN_TIMEOUT, 64, maximum DRAIN cycles before sleep is abandoned; 0 disables the timeout
CNT_W, 8, counter width; must satisfy 2^CNT_W > max(WAKE_DELAY, DRAIN_TIMEOUT)

Ports:
clk_ungated_i  in  1  free-running clock
rst_n  in  1  reset, asynchronous, active-low
fetch_enable_i  in  1  fetch enable; made sticky internally (fetch_en_q)
wfi_req_i  in  1  single-cycle pulse from controller: WFI reached ID
debug_wfi_no_sleep_i  in  1  debug scenario; WFI must not sleep
irq_pending_i  in  1  enabled interrupt pending (level)
debug_req_i  in  1  debug request (level)
if_busy_i  in  1  fetch busy
lsu_busy_i  in  1  LSU outstanding transaction
apu_busy_i  in  1  APU outstanding operation
clock_en_o  out  1  enable for the core clock gate
core_sleep_o  out  1  core is asleep
wake_from_sleep_o  out  1  wake event detected in SLEEP
wfi_done_o  out  1  registered pulse: WFI complete, controller may proceed
drain_timeout_o  out  1  registered pulse: drain timed out, sleep abandoned
state_o  out  2  FSM state: RUN=0, DRAIN=1, SLEEP=2, WAKE=3

Behaviour:
- Signal definitions:
  - wake = irq_pending_i | debug_req_i
  - busy = if_busy_i | lsu_busy_i | apu_busy_i
- Reset values: state=RUN, fetch_en_q=0, cnt=0, wfi_done_o=0, drain_timeout_o=0.
  - Consequently clock_en_o=0, core_sleep_o=0, wake_from_sleep_o=0 in reset.
- fetch_en_q: set on fetch_enable_i; cleared only by reset.
- Combinational outputs:
  - clock_en_o = fetch_en_q & ((state!=SLEEP) | wake)
  - core_sleep_o = fetch_en_q & (state==SLEEP) & !wake
  - wake_from_sleep_o = (state==SLEEP) & wake
- While fetch_en_q=0: FSM held in RUN; wfi_req_i ignored.
- RUN: on wfi_req_i, the first matching branch applies:
  - debug_wfi_no_sleep_i=1 → stay in RUN; wfi_done_o=1 next cycle.
  - wake=1 → stay in RUN; wfi_done_o=1 next cycle.
  - otherwise → DRAIN, cnt=0.
- DRAIN: branch priority is wake > !busy > timeout > count.
  - wake → RUN; wfi_done_o next cycle (aborted sleep).
  - !busy → SLEEP.
  - DRAIN_TIMEOUT!=0 and cnt==DRAIN_TIMEOUT-1 → RUN; wfi_done_o and drain_timeout_o next cycle.
  - otherwise cnt++.
- SLEEP: clock gated; no internal register changes while !wake, so clk_i may be gated externally.
  - On wake: if WAKE_DELAY==0 → RUN with wfi_done_o next cycle; otherwise → WAKE, cnt=0.
  - clock_en_o rises combinationally in the same cycle wake is seen.
- WAKE: clock_en_o=1; cnt++.
  - When cnt==WAKE_DELAY-1 → RUN, wfi_done_o next cycle.
  - wake deasserting during WAKE has no effect; the sequence completes.
- wfi_req_i outside RUN is ignored; this is a protocol error and is flagged by an assertion.
- wfi_done_o and drain_timeout_o are exactly one cycle wide. Exactly one wfi_done_o is issued per accepted wfi_req_i.
- Counter: saturating is not required; the range is guaranteed by the CNT_W rule. cnt is cleared on every state entry.
- Assertions (under CV32E40P_ASSERT_ON):
  - core_sleep_o → !clock_en_o
  - core_sleep_o → !busy
  - fetch_en_q==0 → clock_en_o==0
  - at most one wfi_done_o between consecutive accepted wfi_req_i

Test Plan:
1. Basic sleep and wake:
   - Stimulus: fetch_enable pulse; wfi_req with busy=0; wake raised 10 cycles later (WAKE_DELAY=2).
   - Response: DRAIN at t+1, SLEEP at t+2, core_sleep_o=1 and clock_en_o=0. On wake, clock_en_o=1 the same cycle; WAKE for 2 cycles; wfi_done_o pulses once.
2. Drain wait:
   - Stimulus: lsu_busy held 5 cycles after wfi_req.
   - Response: state stays DRAIN for 5 cycles, then SLEEP; clock_en_o=1 throughout DRAIN.
3. Drain timeout:
   - Stimulus: DRAIN_TIMEOUT=4, if_busy stuck at 1.
   - Response: after 4 DRAIN cycles, state returns to RUN; wfi_done_o and drain_timeout_o pulse together; core_sleep_o never 1.
4. Sleep bypass:
   - Stimulus: wfi_req with debug_wfi_no_sleep_i=1; separately, wfi_req with irq_pending_i=1.
   - Response: in both cases state stays RUN and wfi_done_o=1 next cycle.
5. Pre-enable and zero delay:
   - Stimulus: wfi_req before fetch_enable.
   - Response: ignored, clock_en_o=0. Then with WAKE_DELAY=0, a wake in SLEEP gives RUN and wfi_done_o the next cycle.
6. Reset mid-sleep:
   - Stimulus: rst_n asserted low while in SLEEP.
   - Response: state=RUN, clock_en_o=0, core_sleep_o=0 immediately (asynchronous). The core stays gated until fetch_enable_i is asserted again.

Source files
------------

// File: rtl/cv32e40p_wfi_sleep_sequencer.sv
// -----------------------------------------------------------------------------
// cv32e40p_wfi_sleep_sequencer
//
// Sequences WFI sleep entry and exit for the core clock gate. Runs on the
// free-running clock so it keeps working while the core clock is gated.
// A WFI request from the controller waits for IF/LSU/APU to drain, then the
// core clock is gated. A wake event ungates the clock, a fixed settle delay
// elapses, and completion is returned to the controller.
//
// Ports:
//   clk_ungated_i         free-running clock
//   rst_n                 asynchronous active-low reset
//   fetch_enable_i        fetch enable, made sticky internally
//   wfi_req_i             single-cycle pulse: WFI reached ID
//   debug_wfi_no_sleep_i  WFI must not sleep (debug scenario)
//   irq_pending_i         enabled interrupt pending (level)
//   debug_req_i           debug request (level)
//   if_busy_i/lsu_busy_i/apu_busy_i  outstanding activity in the pipeline
//   clock_en_o            enable for the core clock gate
//   core_sleep_o          core is asleep
//   wake_from_sleep_o     wake event seen while asleep
//   wfi_done_o            registered pulse: WFI complete
//   drain_timeout_o       registered pulse: drain timed out, sleep abandoned
//   state_o               RUN=0, DRAIN=1, SLEEP=2, WAKE=3
// -----------------------------------------------------------------------------
module cv32e40p_wfi_sleep_sequencer #(
    parameter int unsigned WAKE_DELAY    = 2,
    parameter int unsigned DRAIN_TIMEOUT = 64,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk_ungated_i,
    input  logic       rst_n,
    input  logic       fetch_enable_i,
    input  logic       wfi_req_i,
    input  logic       debug_wfi_no_sleep_i,
    input  logic       irq_pending_i,
    input  logic       debug_req_i,
    input  logic       if_busy_i,
    input  logic       lsu_busy_i,
    input  logic       apu_busy_i,
    output logic       clock_en_o,
    output logic       core_sleep_o,
    output logic       wake_from_sleep_o,
    output logic       wfi_done_o,
    output logic       drain_timeout_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    // Terminal counter values; the zero-parameter cases never reach the compare.
    localparam logic             DRAIN_TO_EN = (DRAIN_TIMEOUT != 32'd0);
    localparam logic             WAKE_BYPASS = (WAKE_DELAY == 32'd0);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = DRAIN_TO_EN ? CNT_W'(DRAIN_TIMEOUT - 32'd1) : '0;
    localparam logic [CNT_W-1:0] WAKE_LAST   = WAKE_BYPASS ? '0 : CNT_W'(WAKE_DELAY - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);

    state_e           state_r;
    state_e           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             fetch_en_q;
    logic             wfi_done_r;
    logic             wfi_done_s;
    logic             drain_timeout_r;
    logic             drain_timeout_s;
    logic             wake_s;
    logic             busy_s;

    assign wake_s = irq_pending_i | debug_req_i;
    assign busy_s = if_busy_i | lsu_busy_i | apu_busy_i;

    // Next-state, counter and completion-pulse decode.
    always_comb begin
        state_s         = state_r;
        cnt_s           = cnt_r;
        wfi_done_s      = 1'b0;
        drain_timeout_s = 1'b0;
        if (!fetch_en_q) begin
            // Core never started: park in RUN and ignore WFI.
            state_s = ST_RUN;
            cnt_s   = '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (wfi_req_i) begin
                        if (debug_wfi_no_sleep_i || wake_s) begin
                            wfi_done_s = 1'b1;
                        end else begin
                            state_s = ST_DRAIN;
                            cnt_s   = '0;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (wake_s) begin
                        state_s    = ST_RUN;
                        cnt_s      = '0;
                        wfi_done_s = 1'b1;
                    end else if (!busy_s) begin
                        state_s = ST_SLEEP;
                        cnt_s   = '0;
                    end else if (DRAIN_TO_EN && (cnt_r == DRAIN_LAST)) begin
                        state_s         = ST_RUN;
                        cnt_s           = '0;
                        wfi_done_s      = 1'b1;
                        drain_timeout_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_SLEEP: begin
                    // Nothing changes without a wake, so the core clock may stay gated.
                    if (wake_s) begin
                        cnt_s = '0;
                        if (WAKE_BYPASS) begin
                            state_s    = ST_RUN;
                            wfi_done_s = 1'b1;
                        end else begin
                            state_s = ST_WAKE;
                        end
                    end else begin
                        state_s = ST_SLEEP;
                    end
                end
                ST_WAKE: begin
                    // Settle delay runs to completion even if wake drops.
                    if (cnt_r == WAKE_LAST) begin
                        state_s    = ST_RUN;
                        cnt_s      = '0;
                        wfi_done_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_RUN;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // State, counter and registered pulse outputs.
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_RUN;
            cnt_r           <= '0;
            wfi_done_r      <= 1'b0;
            drain_timeout_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            cnt_r           <= cnt_s;
            wfi_done_r      <= wfi_done_s;
            drain_timeout_r <= drain_timeout_s;
        end
    end

    // Sticky fetch enable: once the core is started it stays started until reset.
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            fetch_en_q <= 1'b0;
        end else if (fetch_enable_i) begin
            fetch_en_q <= 1'b1;
        end else begin
            fetch_en_q <= fetch_en_q;
        end
    end

    // The clock gate opens in the same cycle a wake is seen in SLEEP.
    assign clock_en_o        = fetch_en_q & ((state_r != ST_SLEEP) | wake_s);
    assign core_sleep_o      = fetch_en_q & (state_r == ST_SLEEP) & ~wake_s;
    assign wake_from_sleep_o = (state_r == ST_SLEEP) & wake_s;
    assign wfi_done_o        = wfi_done_r;
    assign drain_timeout_o   = drain_timeout_r;
    assign state_o           = state_r;

`ifdef CV32E40P_ASSERT_ON
    cv32e40p_wfi_sleep_sequencer_checker u_checker (
        .clk_ungated_i (clk_ungated_i),
        .rst_n         (rst_n),
        .fetch_en_q    (fetch_en_q),
        .wfi_req_i     (wfi_req_i),
        .in_run        (state_r == ST_RUN),
        .busy          (busy_s),
        .clock_en      (clock_en_o),
        .core_sleep    (core_sleep_o),
        .wfi_done      (wfi_done_o)
    );
`endif

endmodule

`ifdef CV32E40P_ASSERT_ON
// -----------------------------------------------------------------------------
// Property checker for the sleep sequencer: clock-gate consistency, drain
// completeness, and one completion per accepted WFI.
// -----------------------------------------------------------------------------
module cv32e40p_wfi_sleep_sequencer_checker (
    input logic clk_ungated_i,
    input logic rst_n,
    input logic fetch_en_q,
    input logic wfi_req_i,
    input logic in_run,
    input logic busy,
    input logic clock_en,
    input logic core_sleep,
    input logic wfi_done
);
    logic accept_s;
    logic done_seen_r;

    assign accept_s = fetch_en_q & wfi_req_i & in_run;

    // Remembers whether the current accepted WFI has already completed.
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            done_seen_r <= 1'b0;
        end else if (accept_s) begin
            done_seen_r <= 1'b0;
        end else if (wfi_done) begin
            done_seen_r <= 1'b1;
        end else begin
            done_seen_r <= done_seen_r;
        end
    end

    a_sleep_gated:  assert property (@(posedge clk_ungated_i) disable iff (!rst_n) core_sleep |-> !clock_en);
    a_sleep_idle:   assert property (@(posedge clk_ungated_i) disable iff (!rst_n) core_sleep |-> !busy);
    a_no_fetch:     assert property (@(posedge clk_ungated_i) disable iff (!rst_n) !fetch_en_q |-> !clock_en);
    a_single_done:  assert property (@(posedge clk_ungated_i) disable iff (!rst_n) wfi_done |-> !done_seen_r);
    a_req_protocol: assert property (@(posedge clk_ungated_i) disable iff (!rst_n) (wfi_req_i & fetch_en_q) |-> in_run);
endmodule
`endif
